// File: rtl/if_stage_hs_if.sv
// Instruction SRAM-like bus between the fetch stage and the instruction memory.
//   req     : request valid (master -> slave)
//   addr    : request address, held stable with req
//   addr_ok : request accepted; a handshake is req & addr_ok
//   data_ok : one read word returned, in request order
//   rdata   : returned word, valid with data_ok
interface if_stage_hs_if;
   logic        req;
   logic [31:0] addr;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (output req, addr, input addr_ok, data_ok, rdata);
   modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_stage_hs.sv
// Fetch stage with pre-IF for a MIPS pipeline.
// Issues in-order requests on an SRAM-like instruction bus, keeps allocated
// requests and returned words in a small circular buffer, and presents them
// to ID in program order. Branches keep the delay slot and cancel younger
// fetches; flushes drop everything and discard late responses. A misaligned
// fetch PC produces an AdEL entry and halts fetching until the next flush.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ds_allowin            ID can accept an instruction this cycle
//   br_stall              hold new requests while ID branch operands resolve
//   br_taken, br_target   taken-branch pulse and its target
//   flush, flush_pc       exception/eret flush pulse and restart address
//   fs_to_ds_*            instruction presented to ID (valid, pc, inst, adel)
//   inst_sram             instruction bus master (req/addr/addr_ok/data_ok/rdata)
module if_stage_hs #(
   parameter logic [31:0] RESET_PC   = 32'hbfc00000,
   parameter int          IBUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ds_allowin,
   input  logic              br_stall,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   input  logic              flush,
   input  logic [31:0]       flush_pc,
   output logic              fs_to_ds_valid,
   output logic [31:0]       fs_to_ds_pc,
   output logic [31:0]       fs_to_ds_inst,
   output logic              fs_to_ds_adel,
   if_stage_hs_if.master     inst_sram
);

   localparam int AW = $clog2(IBUF_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]           pc_next;
   logic [31:0]           redirect_target;
   logic                  redirect_pending;
   logic                  halted;
   logic [CW-1:0]         count;
   logic [CW-1:0]         discard;
   logic [AW-1:0]         head;
   logic [AW-1:0]         tail;

   logic [31:0]           pc_q   [IBUF_DEPTH];
   logic [31:0]           inst_q [IBUF_DEPTH];
   logic [IBUF_DEPTH-1:0] filled_q;
   logic [IBUF_DEPTH-1:0] cancel_q;
   logic [IBUF_DEPTH-1:0] adel_q;

   logic                  full;
   logic                  misaligned;
   logic                  fetch_ok;
   logic                  req;
   logic                  hs;
   logic                  adel_alloc;
   logic                  alloc;
   logic                  pop;
   logic                  fill_found;
   logic [AW-1:0]         fill_ptr;
   logic                  live_found;
   logic [AW-1:0]         live_off;
   logic [CW-1:0]         unfilled_cnt;
   logic                  use_data;

   assign full       = (count == CW'(IBUF_DEPTH));
   assign misaligned = (pc_next[1:0] != 2'b00);
   assign fetch_ok   = ~br_stall & ~flush & ~halted & ~full;
   assign req        = ~reset & fetch_ok & ~misaligned;
   assign hs         = req & inst_sram.addr_ok;
   assign adel_alloc = ~reset & fetch_ok & misaligned;
   assign alloc      = hs | adel_alloc;

   assign inst_sram.req  = req;
   assign inst_sram.addr = pc_next;

   assign fs_to_ds_valid = (count != '0) & filled_q[head] & ~cancel_q[head] & ~flush;
   assign fs_to_ds_pc    = pc_q[head];
   assign fs_to_ds_inst  = inst_q[head];
   assign fs_to_ds_adel  = fs_to_ds_valid & adel_q[head];

   // A cancelled head leaves silently once its word has arrived.
   assign pop = (count != '0) & filled_q[head] & (cancel_q[head] | (ds_allowin & ~flush));

   // Scan from the head: oldest unfilled entry (fill target), oldest live
   // entry (delay slot on a taken branch), and the number of unfilled entries.
   always_comb begin
      fill_found   = 1'b0;
      fill_ptr     = head;
      live_found   = 1'b0;
      live_off     = '0;
      unfilled_cnt = '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
         if (CW'(i) < count) begin
            if (!filled_q[head + AW'(i)]) begin
               unfilled_cnt = unfilled_cnt + CW'(1);
               if (!fill_found) begin
                  fill_found = 1'b1;
                  fill_ptr   = head + AW'(i);
               end
            end
            if (!cancel_q[head + AW'(i)] && !live_found) begin
               live_found = 1'b1;
               live_off   = AW'(i);
            end
         end
      end
   end

   // Responses owed to requests dropped by a flush are consumed first.
   assign use_data = inst_sram.data_ok & (discard == '0) & fill_found;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_next          <= RESET_PC;
         redirect_target  <= '0;
         redirect_pending <= 1'b0;
         halted           <= 1'b0;
         count            <= '0;
         discard          <= '0;
         head             <= '0;
         tail             <= '0;
         filled_q         <= '0;
         cancel_q         <= '0;
         adel_q           <= '0;
         for (int i = 0; i < IBUF_DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
      end else if (flush) begin
         // Every unfilled entry still owes a response; a data_ok arriving
         // now pays one of those (or an older) debt.
         discard          <= discard + unfilled_cnt
                             - CW'(inst_sram.data_ok & ((discard != '0) | (unfilled_cnt != '0)));
         count            <= '0;
         head             <= '0;
         tail             <= '0;
         filled_q         <= '0;
         cancel_q         <= '0;
         adel_q           <= '0;
         pc_next          <= flush_pc;
         halted           <= 1'b0;
         redirect_pending <= 1'b0;
      end else begin
         if (use_data) begin
            filled_q[fill_ptr] <= 1'b1;
            inst_q[fill_ptr]   <= inst_sram.rdata;
         end else if (inst_sram.data_ok && discard != '0) begin
            discard <= discard - CW'(1);
         end

         if (br_taken && live_found) begin
            for (int i = 0; i < IBUF_DEPTH; i++) begin
               if (CW'(i) < count && AW'(i) > live_off)
                  cancel_q[head + AW'(i)] <= 1'b1;
            end
         end

         if (pop) begin
            filled_q[head] <= 1'b0;
            cancel_q[head] <= 1'b0;
            head           <= head + AW'(1);
         end

         if (alloc) begin
            pc_q[tail]     <= pc_next;
            inst_q[tail]   <= '0;
            filled_q[tail] <= adel_alloc;
            adel_q[tail]   <= adel_alloc;
            cancel_q[tail] <= br_taken & live_found;
            tail           <= tail + AW'(1);
         end

         count <= count + CW'(alloc) - CW'(pop);

         if (adel_alloc)
            halted <= 1'b1;

         // With no live entry and no handshake the delay slot is not yet
         // fetched, so the target waits until that request goes out.
         if (br_taken) begin
            if (live_found || hs) begin
               pc_next          <= br_target;
               redirect_pending <= 1'b0;
            end else begin
               redirect_pending <= 1'b1;
               redirect_target  <= br_target;
            end
         end else if (hs) begin
            if (redirect_pending) begin
               pc_next          <= redirect_target;
               redirect_pending <= 1'b0;
            end else begin
               pc_next <= pc_next + 32'd4;
            end
         end
      end
   end

endmodule
